// File: rtl/piano_voice_ctrl.sv
// Voice allocator / command sequencer: frames 2-byte note-on/off commands from the UART
// and manages NUM_VOICES tone slots with hold timeout. Build option: PIANO_VOICE_STEAL_EN.
module piano_voice_ctrl #(
  parameter int NUM_VOICES = 4,
  parameter int TIMEOUT    = 50000,
  parameter int TMR_W      = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              rx_byte,
  input  logic                    rx_done,
  output logic [NUM_VOICES-1:0]   voice_en,
  output logic [7*NUM_VOICES-1:0] voice_note,
  output logic                    frame_err,
  output logic                    note_drop
);

  localparam int              IDX_W    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, EXEC = 2'd2} state_t;

  state_t                 state, state_nxt;
  logic                   hdr_on;
  logic [6:0]             note_lat;
  logic [6:0]             note_r [NUM_VOICES];
  logic [TMR_W-1:0]       cnt_r  [NUM_VOICES];

  logic [NUM_VOICES-1:0]  en_d;
  logic [6:0]             note_d [NUM_VOICES];
  logic [TMR_W-1:0]       cnt_d  [NUM_VOICES];
  logic                   ferr_d, drop_d;
  logic [NUM_VOICES-1:0]  hit;
  logic [IDX_W-1:0]       free_idx;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // EXEC behaves like IDLE for a byte arriving while the command is applied
  always_comb begin
    state_nxt = state;
    case (state)
      HDR:     if (rx_done && !rx_byte[7]) state_nxt = EXEC;
      default: state_nxt = (rx_done && rx_byte[7]) ? HDR : IDLE;
    endcase
  end

`ifdef PIANO_VOICE_STEAL_EN
  logic [IDX_W-1:0] old_idx;
  logic [TMR_W-1:0] old_cnt;

  // Largest counter is the oldest voice; strict compare keeps ties on the lowest index
  always_comb begin
    old_idx = '0;
    old_cnt = cnt_r[0];
    for (int v = 1; v < NUM_VOICES; v++) begin
      if (cnt_r[v] > old_cnt) begin
        old_cnt = cnt_r[v];
        old_idx = IDX_W'(v);
      end
    end
  end
`endif

  always_comb begin
    en_d     = voice_en;
    drop_d   = 1'b0;
    ferr_d   = rx_done && ((rx_byte[7] && state == HDR) || (!rx_byte[7] && state != HDR));
    hit      = '0;
    free_idx = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      note_d[v] = note_r[v];
      hit[v]    = voice_en[v] && (note_r[v] == note_lat);
      if (!voice_en[v])            cnt_d[v] = '0;
      else if (cnt_r[v] == TMR_LAST) begin
        cnt_d[v] = '0;
        en_d[v]  = 1'b0;
      end else                     cnt_d[v] = cnt_r[v] + TMR_W'(1);
    end
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (!voice_en[v]) free_idx = IDX_W'(v);
    end
    // Command decisions use pre-edge voice_en and override any same-edge timeout
    if (state == EXEC) begin
      if (!hdr_on || (|hit)) begin
        for (int v = 0; v < NUM_VOICES; v++) begin
          if (hit[v]) begin
            en_d[v]  = hdr_on;
            cnt_d[v] = '0;
          end
        end
      end else if (!(&voice_en)) begin
        en_d[free_idx]   = 1'b1;
        note_d[free_idx] = note_lat;
        cnt_d[free_idx]  = '0;
      end else begin
`ifdef PIANO_VOICE_STEAL_EN
        en_d[old_idx]   = 1'b1;
        note_d[old_idx] = note_lat;
        cnt_d[old_idx]  = '0;
`else
        drop_d = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      voice_en  <= '0;
      frame_err <= 1'b0;
      note_drop <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        note_r[v] <= '0;
        cnt_r[v]  <= '0;
      end
    end else begin
      voice_en  <= en_d;
      frame_err <= ferr_d;
      note_drop <= drop_d;
      for (int v = 0; v < NUM_VOICES; v++) begin
        note_r[v] <= note_d[v];
        cnt_r[v]  <= cnt_d[v];
      end
    end
  end

  // Header type and note are only consumed when the FSM says so
  always_ff @(posedge clk) begin
    if (rx_done && rx_byte[7])                 hdr_on   <= rx_byte[6];
    if (rx_done && !rx_byte[7] && state == HDR) note_lat <= rx_byte[6:0];
  end

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_note
    assign voice_note[7*g +: 7] = note_r[g];
  end

endmodule

// File: doc/piano_voice_ctrl.md
# piano_voice_ctrl

Voice allocator and command sequencer between the UART receiver and the tone generators of the Bluetooth piano. It frames the received byte stream into 2-byte note-on/note-off commands and assigns each note to one of NUM_VOICES shared tone-generator slots. It releases notes on command or on a hold timeout, so a dropped link never leaves a stuck tone.

## Interface
- NUM_VOICES, 4: number of tone-generator slots (1..8).
- TIMEOUT, 50000: clk cycles a voice stays on without retrigger before auto-release (≥2).
- TMR_W, 16: width of per-voice hold counters; TIMEOUT-1 must fit.

- clk  in  1  system clock, same domain as the UART receiver.
- reset  in  1  synchronous, active-high reset.
- rx_byte  in  8  received byte; valid when rx_done=1.
- rx_done  in  1  single-cycle byte-received strobe.
- voice_en  out  NUM_VOICES  bit v=1: slot v is sounding.
- voice_note  out  7*NUM_VOICES  note number of slot v in bits [7v+6:7v]; held after release.
- frame_err  out  1  one-cycle pulse on a protocol violation.
- note_drop  out  1  one-cycle pulse when a note-on finds no free slot (non-steal build).

## Operation
- Byte classes: bit7=1 is a header, with bit6=1 for note-on and 0 for note-off (bits5:0 ignored). bit7=0 is data, with note = bits6:0.
- FSM states are IDLE, HDR and EXEC.
  - IDLE: a header moves to HDR and latches on/off. Data gives a frame_err pulse, is discarded and stays in IDLE.
  - HDR: data latches the note and moves to EXEC. A header gives a frame_err pulse, replaces the latched header and stays in HDR (resync).
  - EXEC: applies the command and leaves in one cycle. If rx_done=1 in EXEC, the next state is what IDLE would give for that byte; the command is still applied.
- Note-on:
  - If any active slot holds the same note, retrigger it: clear its counter, no allocation.
  - Otherwise allocate the lowest-index slot with voice_en=0: write the note, set en and clear the counter.
  - If there is no free slot, see Configuration.
- Note-off: clears en of every active slot holding that note. An unknown note has no effect and no error.
- Hold timer:
  - Each active slot's counter increments every cycle.
  - When it equals TIMEOUT-1, en clears on that edge and the counter resets to 0.
  - Inactive counters hold at 0.
- Simultaneous events:
  - An EXEC action on a slot wins over that slot's timeout on the same edge.
  - Allocation uses the pre-edge voice_en, so an expiring slot counts as busy.

## Timing
- rx_done of the data byte is sampled at edge E, so the FSM is in EXEC during the cycle after E. voice_en/voice_note update at E+1.
- frame_err asserts for exactly the cycle after the offending byte's rx_done edge.
- note_drop asserts for exactly the cycle after EXEC.
- Reset (synchronous, any state, including mid-frame) gives:
  - state IDLE
  - voice_en=0
  - voice_note=0
  - all counters 0
  - frame_err=0
  - note_drop=0
- Reset discards a pending header.
- All outputs are registered.

## Configuration
- PIANO_VOICE_STEAL_EN defined: a note-on with no free slot steals the active slot with the largest counter value (oldest; ties go to the lowest index). That slot's note is written, en stays 1 and its counter clears. note_drop is constant 0.
- Not defined: the note-on is discarded, all slots are unchanged and note_drop pulses one cycle. No age-compare logic is built.

## Test plan
- Reset, then send 0xC0, 0x3C: voice_en=0001 and voice_note[6:0]=0x3C at E+1. Then send 0x80, 0x3C: voice_en=0000 and voice_note[6:0] remains 0x3C.
- Send data 0x3C in IDLE: frame_err pulses once and voice_en is unchanged. Send 0xC0, 0xC0, 0x40: one frame_err pulse, then slot 0 = 0x40.
- Send note-on 0x30, 0x31, 0x32, 0x33 (NUM_VOICES=4), then 0x34.
  - Non-steal build: note_drop pulses and slots are unchanged.
  - Steal build: slot 0 becomes 0x34 and note_drop stays 0.
- TIMEOUT=20, note-on 0x3C, no further bytes: voice_en[0] clears exactly 20 cycles after it set. Retrigger 0x3C at cycle 10: release moves to 20 cycles after the retrigger.
- Assert reset while in HDR with two voices active: all outputs reach reset values next edge. A following data byte gives frame_err and no allocation.
